// File: rtl/tl_pkg.sv
// tl_pkg: shared constants and types for the transaction-layer referee.
//   LINE_SIZE / NUM_PORTS : FIFO line width and port count of the FIFO banks
//   DEST_MSB / DEST_W     : position of the 2-bit destination field in a word
//   state_t               : referee FSM encoding (IDLE/GRANT/STALL)
//   oh2idx()              : one-hot (4 bit) to binary index
package tl_pkg;

    localparam int LINE_SIZE = 12;
    localparam int NUM_PORTS = 4;
    localparam int DEST_MSB  = LINE_SIZE - 1;
    localparam int DEST_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        oh2idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) oh2idx = 2'(i);
        end
    endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: combinational 4-way round-robin arbiter.
//   i_req   [3:0] request vector
//   i_ptr   [1:0] highest-priority requester this cycle
//   o_gnt   [3:0] one-hot grant (first request at or above i_ptr, mod 4)
//   o_valid       some request was granted
module rr_arbiter_4
    import tl_pkg::*;
(
    input  logic [3:0] i_req,
    input  logic [1:0] i_ptr,
    output logic [3:0] o_gnt,
    output logic       o_valid
);

    always_comb begin
        o_gnt   = 4'b0000;
        o_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] w_idx;
            w_idx = i_ptr + 2'(k);   // wraps naturally at 2 bits
            if (!o_valid && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                o_valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tl_referee.sv
// tl_referee: drains four FWFT input FIFOs and routes each word to one of four
// output FIFOs selected by the word's 2-bit destination field.
//   clk, reset       : clock (rising edge), async active-high reset
//   in_empty         : per-input empty flags
//   in_data          : head words, slice i = [i*LINE_SIZE +: LINE_SIZE]
//   out_almost_full  : per-output almost-full flags
//   pop / push       : registered one-hot strobes to input / output FIFOs
//   data_out         : registered word, valid while push != 0
//   state            : FSM state (0 IDLE, 1 GRANT, 2 STALL), aligned with pop/push
//   grant_cnt        : wrapping count of transferred words
module tl_referee
    import tl_pkg::*;
#(
    parameter int LINE_SIZE = tl_pkg::LINE_SIZE,
    parameter int DEST_MSB  = LINE_SIZE - 1,
    parameter int NUM_PORTS = tl_pkg::NUM_PORTS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORTS-1:0]           in_empty,
    input  logic [NUM_PORTS*LINE_SIZE-1:0] in_data,
    input  logic [NUM_PORTS-1:0]           out_almost_full,
    output logic [NUM_PORTS-1:0]           pop,
    output logic [NUM_PORTS-1:0]           push,
    output logic [LINE_SIZE-1:0]           data_out,
    output logic [1:0]                     state,
    output logic [7:0]                     grant_cnt
);

    logic [3:0]           r_pop, r_push;
    logic [LINE_SIZE-1:0] r_data;
    logic [1:0]           r_ptr;
    logic [7:0]           r_cnt;
    logic                 r_rdy;
    state_t               r_state, w_nstate;

    logic [1:0]           w_dest [4];
    logic [3:0]           w_req, w_gnt;
    logic                 w_valid;
    logic [1:0]           w_win;
    logic [1:0]           w_win_dest;
    logic [LINE_SIZE-1:0] w_win_data;

    // An input whose pop is in flight still shows its old head this cycle,
    // so it sits out one decision. r_rdy holds off grants for the first cycle
    // after reset so the FIFO flags have settled.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_dest[i] = in_data[i*LINE_SIZE + DEST_MSB -: 2];
            w_req[i]  = r_rdy & ~in_empty[i] & ~out_almost_full[w_dest[i]] & ~r_pop[i];
        end
    end

    rr_arbiter_4 u_arb (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_gnt),
        .o_valid (w_valid)
    );

    assign w_win      = oh2idx(w_gnt);
    assign w_win_dest = w_dest[w_win];
    assign w_win_data = in_data[int'(w_win)*LINE_SIZE +: LINE_SIZE];

    always_comb begin
        w_nstate = ST_STALL;
        if (&in_empty)    w_nstate = ST_IDLE;
        else if (w_valid) w_nstate = ST_GRANT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_nstate;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pop  <= 4'b0000;
            r_push <= 4'b0000;
            r_data <= '0;
            r_ptr  <= 2'd0;
            r_cnt  <= 8'd0;
            r_rdy  <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
            if (w_valid) begin
                r_pop  <= w_gnt;
                r_push <= 4'b0001 << w_win_dest;
                r_data <= w_win_data;
                r_ptr  <= w_win + 2'd1;
                r_cnt  <= r_cnt + 8'd1;
            end else begin
                r_pop  <= 4'b0000;
                r_push <= 4'b0000;
            end
        end
    end

    assign pop       = r_pop;
    assign push      = r_push;
    assign data_out  = r_data;
    assign state     = r_state;
    assign grant_cnt = r_cnt;

endmodule

// File: tb/tb_tl_referee.sv
module tb_tl_referee;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  in_empty = 4'b1111;
    logic [47:0] in_data = '0;
    logic [3:0]  out_almost_full = 4'b0000;
    logic [3:0]  pop, push;
    logic [11:0] data_out;
    logic [1:0]  state;
    logic [7:0]  grant_cnt;

    int checks = 0;
    int failures = 0;

    // scoreboard entry: {pop, push, data_out, state, grant_cnt}
    logic [29:0] sb[$];
    logic [29:0] e, got;
    logic [7:0]  exp_cnt;
    logic [11:0] exp_data;

    // Round-robin words: input i targets destination 3-i
    logic [11:0] rr_w [4];

    tl_referee dut (
        .clk             (clk),
        .reset           (reset),
        .in_empty        (in_empty),
        .in_data         (in_data),
        .out_almost_full (out_almost_full),
        .pop             (pop),
        .push            (push),
        .data_out        (data_out),
        .state           (state),
        .grant_cnt       (grant_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_word(input int i, input logic [11:0] w);
        in_data[i*12 +: 12] = w;
    endtask

    // Expected outputs after the next unchecked edge
    task automatic exp_edge(input logic [3:0] p, input logic [3:0] q,
                            input logic [11:0] d, input logic [1:0] s);
        if (p != 4'b0000) begin
            exp_cnt  = exp_cnt + 8'd1;
            exp_data = d;
        end
        sb.push_back({p, q, exp_data, s, exp_cnt});
    endtask

    // Reset pulse; deasserted 1 time unit after an edge so the next edge is edge 1
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_cnt  = 8'd0;
        exp_data = 12'h000;
        sb.delete();
    endtask

    task automatic set_rr_inputs();
        in_empty = 4'b0000;
        out_almost_full = 4'b0000;
        for (int i = 0; i < 4; i++) set_word(i, rr_w[i]);
    endtask

    task automatic test_reset();
        set_rr_inputs();
        do_reset();
        exp_edge(4'b0, 4'b0, 12'h0, S_STALL);
        exp_edge(4'b0001, 4'b1000, rr_w[0], S_GRANT);
        exp_edge(4'b0010, 4'b0100, rr_w[1], S_GRANT);
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            got = {pop, push, data_out, state, grant_cnt};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL reset_pre: got %h expected %h", got, e);
            end
        end
        // mid-cycle reset: outputs must clear before any edge
        @(posedge clk); #3 reset = 1'b1;
        #1;
        got = {pop, push, data_out, state, grant_cnt};
        checks++;
        if (got !== 30'h0) begin
            failures++;
            $display("FAIL reset_async: got %h expected %h", got, 30'h0);
        end
        @(posedge clk); #1 reset = 1'b0;
        exp_cnt = 8'd0; exp_data = 12'h000;
        exp_edge(4'b0, 4'b0, 12'h0, S_STALL);
        exp_edge(4'b0001, 4'b1000, rr_w[0], S_GRANT);
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            got = {pop, push, data_out, state, grant_cnt};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL reset_first_grant: got %h expected %h", got, e);
            end
        end
    endtask

    task automatic test_single();
        in_empty = 4'b1110;
        out_almost_full = 4'b0000;
        set_word(0, 12'h8A5);
        set_word(1, 12'hC01); set_word(2, 12'h002); set_word(3, 12'h403);
        do_reset();
        exp_edge(4'b0, 4'b0, 12'h0, S_STALL);
        for (int k = 0; k < 3; k++) begin
            exp_edge(4'b0001, 4'b0100, 12'h8A5, S_GRANT);
            exp_edge(4'b0000, 4'b0000, 12'h0, S_STALL);
        end
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            got = {pop, push, data_out, state, grant_cnt};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL single: got %h expected %h", got, e);
            end
        end
    endtask

    task automatic test_round_robin();
        set_rr_inputs();
        do_reset();
        exp_edge(4'b0, 4'b0, 12'h0, S_STALL);
        for (int k = 0; k < 9; k++)
            exp_edge(4'b0001 << (k % 4), 4'b1000 >> (k % 4), rr_w[k % 4], S_GRANT);
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            got = {pop, push, data_out, state, grant_cnt};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL round_robin: got %h expected %h", got, e);
            end
        end
    endtask

    task automatic test_backpressure();
        in_empty = 4'b1100;
        out_almost_full = 4'b1000;
        set_word(0, 12'hC5A); set_word(1, 12'h0B6);
        set_word(2, 12'hFFF); set_word(3, 12'hFFF);
        do_reset();
        exp_edge(4'b0, 4'b0, 12'h0, S_STALL);
        exp_edge(4'b0010, 4'b0001, 12'h0B6, S_GRANT);
        exp_edge(4'b0, 4'b0, 12'h0, S_STALL);
        exp_edge(4'b0010, 4'b0001, 12'h0B6, S_GRANT);
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            got = {pop, push, data_out, state, grant_cnt};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL backpressure_blocked: got %h expected %h", got, e);
            end
        end
        out_almost_full = 4'b0000;
        exp_edge(4'b0001, 4'b1000, 12'hC5A, S_GRANT);
        exp_edge(4'b0010, 4'b0001, 12'h0B6, S_GRANT);
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            got = {pop, push, data_out, state, grant_cnt};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL backpressure_release: got %h expected %h", got, e);
            end
        end
    endtask

    task automatic test_stall();
        in_empty = 4'b0000;
        out_almost_full = 4'b0010;
        set_word(0, 12'h411); set_word(1, 12'h422);
        set_word(2, 12'h433); set_word(3, 12'h444);
        do_reset();
        for (int k = 0; k < 6; k++) exp_edge(4'b0, 4'b0, 12'h0, S_STALL);
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            got = {pop, push, data_out, state, grant_cnt};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL stall: got %h expected %h", got, e);
            end
        end
        out_almost_full = 4'b0000;
        exp_edge(4'b0001, 4'b0010, 12'h411, S_GRANT);
        exp_edge(4'b0010, 4'b0010, 12'h422, S_GRANT);
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            got = {pop, push, data_out, state, grant_cnt};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL stall_release: got %h expected %h", got, e);
            end
        end
    endtask

    task automatic test_same_dest();
        in_empty = 4'b1010;
        out_almost_full = 4'b0000;
        set_word(0, 12'h4A0); set_word(1, 12'hC00);
        set_word(2, 12'h4C2); set_word(3, 12'h0EE);
        do_reset();
        exp_edge(4'b0, 4'b0, 12'h0, S_STALL);
        for (int k = 0; k < 3; k++) begin
            exp_edge(4'b0001, 4'b0010, 12'h4A0, S_GRANT);
            exp_edge(4'b0100, 4'b0010, 12'h4C2, S_GRANT);
        end
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            got = {pop, push, data_out, state, grant_cnt};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL same_dest: got %h expected %h", got, e);
            end
        end
    endtask

    task automatic test_idle();
        in_empty = 4'b1111;
        out_almost_full = 4'b0000;
        do_reset();
        for (int k = 0; k < 3; k++) exp_edge(4'b0, 4'b0, 12'h0, S_IDLE);
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            got = {pop, push, data_out, state, grant_cnt};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL idle: got %h expected %h", got, e);
            end
        end
    endtask

    task automatic test_wrap();
        set_rr_inputs();
        do_reset();
        exp_edge(4'b0, 4'b0, 12'h0, S_STALL);
        for (int k = 0; k < 258; k++)
            exp_edge(4'b0001 << (k % 4), 4'b1000 >> (k % 4), rr_w[k % 4], S_GRANT);
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            got = {pop, push, data_out, state, grant_cnt};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL wrap: got %h expected %h", got, e);
            end
        end
    endtask

    initial begin
        rr_w[0] = 12'hC11;
        rr_w[1] = 12'h822;
        rr_w[2] = 12'h433;
        rr_w[3] = 12'h044;
        exp_cnt = 8'd0;
        exp_data = 12'h000;
        test_reset();
        test_idle();
        test_single();
        test_round_robin();
        test_backpressure();
        test_stall();
        test_same_dest();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tl_referee.md
Name: tl_referee

Overview:
- Consumer-side arbiter ("referee") for the transaction-layer FIFO bank.
- Drains four input FIFOs and routes each word to one of four output FIFOs. The output FIFO is chosen by a 2-bit destination field in the word.
- Drives the pop strobes of the input FIFOs and the push strobes of the output FIFOs. Obeys their empty and almost_full flags.
- Sits between the ingress FIFO bank and the egress FIFO bank of the transaction layer.

Parameters:
- LINE_SIZE, 12, word width; matches the FIFO line size.
- DEST_MSB, LINE_SIZE-1, upper bit of the destination field. The field is bits [DEST_MSB:DEST_MSB-1] and is a 2-bit output index.
- NUM_PORTS, 4, number of input and of output FIFOs. Fixed at 4; other values are not supported.

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_empty  input  4  per-input FIFO empty flag; bit i = input i
- in_data  input  4*LINE_SIZE  head word of each input FIFO, first-word-fall-through; slice i = [i*LINE_SIZE +: LINE_SIZE]
- out_almost_full  input  4  per-output FIFO almost_full flag
- pop  output  4  registered pop strobes to the input FIFOs; at most one bit set
- push  output  4  registered push strobes to the output FIFOs; at most one bit set
- data_out  output  LINE_SIZE  registered word to the output FIFOs; valid when push != 0
- state  output  2  FSM state: 0=IDLE, 1=GRANT, 2=STALL
- grant_cnt  output  8  wrapping count of words transferred

Behaviour:
- Reset (async, active-high):
  - pop=0, push=0, data_out=0, state=IDLE, grant_cnt=0, rr_ptr=0.
  - Asserting reset mid-transfer drops pop and push immediately, without waiting for a clock edge.
  - First possible grant is on the 2nd rising edge after reset deasserts.
- Eligibility, evaluated every cycle (decision cycle N). Input i is eligible when all of the following hold:
  - in_empty[i]==0
  - out_almost_full[dest_i]==0, where dest_i is the destination field of in_data slice i
  - pop[i]==0 in cycle N, because its head has not advanced yet
- Arbitration:
  - Round-robin, searching from rr_ptr upward modulo 4.
  - The first eligible input wins.
  - A blocked input does not stall the others; there is no head-of-line blocking across inputs.
- Issue, registered with 1-cycle latency. At the edge ending cycle N:
  - pop <= one-hot(winner)
  - push <= one-hot(dest_winner)
  - data_out <= in_data[winner]
  - rr_ptr <= winner+1 (mod 4)
  - grant_cnt <= grant_cnt+1
  - If there is no winner: pop=0, push=0, and data_out holds its value.
- Throughput:
  - Aggregate rate is at most 1 word per cycle.
  - A single input gets at most 1 word every 2 cycles because of the pop-exclusion rule.
- FSM, next state computed in cycle N:
  - IDLE: all in_empty=1.
  - GRANT: a winner exists.
  - STALL: some input is non-empty but none is eligible. Backpressure on every destination, or the only non-empty input was just popped.
  - Any state can reach any state in one cycle. state is registered and aligned with pop/push.
- Boundaries:
  - almost_full is sampled only in the decision cycle. The output FIFO's almost threshold must leave at least 1 free line for the in-flight push.
  - Several inputs may target the same destination: only one is granted per cycle, and the others wait for their round-robin turn.
  - grant_cnt wraps from 255 to 0.
  - in_data of an empty input is ignored.

Decomposition:
- Package tl_pkg holds:
  - constants LINE_SIZE=12 and NUM_PORTS=4
  - destination field position
  - FSM state encodings ST_IDLE, ST_GRANT, ST_STALL
- One natural sub-module: rr_arbiter_4. It is combinational, taking a 4-bit request vector and a 2-bit rr_ptr and producing a one-hot grant plus a valid bit.

Test Plan:
- Reset: assert reset with in_empty=4'b0000 mid-cycle -> pop=0, push=0, state=0 immediately. After deassert, first pop occurs at edge 2.
- Single input: in_empty=4'b1110, in_data[0] has dest=2 and payload 12'h8A5 -> pop=4'b0001, push=4'b0100, data_out=12'h8A5, with bubble cycles between grants (pop pattern 1,0,1,0).
- Round-robin: all four inputs non-empty, each targeting a different destination -> pop sequence 0001, 0010, 0100, 1000, 0001, one per cycle, grant_cnt increments by 1 each cycle.
- Backpressure skip: inputs 0 and 1 non-empty, input 0 dest=3, out_almost_full=4'b1000 -> only input 1 is granted. Input 0 is granted the cycle after out_almost_full[3] falls.
- Total stall: all inputs target dest=1, out_almost_full=4'b0010 -> state=STALL, pop=0, push=0 held for the whole stall.
- Counter wrap: 256 grants -> grant_cnt returns to 0.
